// File: rtl/traffic_ctrl_param.sv
// Two-road traffic light controller with per-line BCD countdown and manual override.
// Latency: lamps and BCD are combinational from state/cnt; state advances on a tick edge.
// Backpressure: none; tick is a free-running enable and every output is always valid.
//
// Ports:
//   clk, reset (sync, active low)      - single clock domain
//   tick                               - one-cycle timing enable, gates all phase timing
//   chedo                              - 1 = automatic cycling, 0 = manual (den selects green)
//   den                                - manual request: 0 = line 1 green, 1 = line 2 green
//   light1/light2                      - {red,yellow,green} one-hot lamps per line
//   bcd1/bcd2                          - {tens,ones} countdown to next lamp change per line
//   disp_en                            - countdown valid (automatic mode, no reload pending)
module traffic_ctrl_param #(
    parameter int T_GREEN  = 22,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int CNT_W    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       chedo,
    input  logic       den,
    output logic [2:0] light1,
    output logic [2:0] light2,
    output logic [7:0] bcd1,
    output logic [7:0] bcd2,
    output logic       disp_en
);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_G1  = 3'd0,
        S_Y1  = 3'd1,
        S_AR1 = 3'd2,
        S_G2  = 3'd3,
        S_Y2  = 3'd4,
        S_AR2 = 3'd5
    } state_t;

    localparam cnt_t LEN_G = cnt_t'(T_GREEN - 1);
    localparam cnt_t LEN_Y = cnt_t'(T_YELLOW - 1);
    localparam cnt_t LEN_A = cnt_t'(T_ALLRED - 1);

    // Offsets added to cnt to reach the next lamp change of the line that is
    // not the one being timed by the current phase.
    localparam logic [7:0] OFS_A   = 8'(T_ALLRED);
    localparam logic [7:0] OFS_YA  = 8'(T_YELLOW + T_ALLRED);
    localparam logic [7:0] OFS_GYA = 8'(T_GREEN + T_YELLOW + T_ALLRED);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   chedo_q, chedo_d;       // edge-detect history, resets to 1 so reset is not an edge
    logic   disp_en_q, disp_en_d;   // chedo seen high at the last non-reset edge

    logic       auto_edge;
    logic [7:0] cnt8;
    logic [7:0] cd1, cd2;

    function automatic cnt_t phase_len_m1(input state_t s);
        case (s)
            S_G1, S_G2: phase_len_m1 = LEN_G;
            S_Y1, S_Y2: phase_len_m1 = LEN_Y;
            default:    phase_len_m1 = LEN_A;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        to_bcd = {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

    // Next-state / counter logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chedo_d   = chedo;
        disp_en_d = chedo;
        auto_edge = chedo & ~chedo_q;

        if (auto_edge) begin
            // Re-entering automatic mode restarts the current phase so the
            // countdown shown is a full, truthful one.
            cnt_d = phase_len_m1(state_q);
        end else if (tick) begin
            if (!chedo && state_q == S_G1) begin
                if (den) begin
                    state_d = S_Y1;
                    cnt_d   = LEN_Y;
                end
            end else if (!chedo && state_q == S_G2) begin
                if (!den) begin
                    state_d = S_Y2;
                    cnt_d   = LEN_Y;
                end
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - cnt_t'(1);
            end else begin
                case (state_q)
                    S_G1:    state_d = S_Y1;
                    S_Y1:    state_d = S_AR1;
                    S_AR1:   state_d = (!chedo && !den) ? S_G1 : S_G2;
                    S_G2:    state_d = S_Y2;
                    S_Y2:    state_d = S_AR2;
                    S_AR2:   state_d = (!chedo && den) ? S_G2 : S_G1;
                    default: state_d = S_G1;
                endcase
                cnt_d = phase_len_m1(state_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_G1;
            cnt_q     <= LEN_G;
            chedo_q   <= 1'b1;
            disp_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chedo_q   <= chedo_d;
            disp_en_q <= disp_en_d;
        end
    end

    // Lamp decode and countdown values
    always_comb begin
        light1 = LAMP_R;
        light2 = LAMP_R;
        cnt8   = 8'(cnt_q);
        cd1    = cnt8;
        cd2    = cnt8;
        case (state_q)
            S_G1: begin
                light1 = LAMP_G;
                cd2    = cnt8 + OFS_YA;
            end
            S_Y1: begin
                light1 = LAMP_Y;
                cd2    = cnt8 + OFS_A;
            end
            S_AR1: begin
                cd1 = cnt8 + OFS_GYA;
            end
            S_G2: begin
                light2 = LAMP_G;
                cd1    = cnt8 + OFS_YA;
            end
            S_Y2: begin
                light2 = LAMP_Y;
                cd1    = cnt8 + OFS_A;
            end
            S_AR2: begin
                cd2 = cnt8 + OFS_GYA;
            end
            default: begin
                light1 = LAMP_R;
                light2 = LAMP_R;
            end
        endcase
    end

    assign bcd1    = to_bcd(cd1);
    assign bcd2    = to_bcd(cd2);
    // The combinational chedo term drops the display at once on a switch to manual.
    assign disp_en = disp_en_q & chedo;

endmodule

// File: doc/traffic_ctrl_param.md
TRAFFIC_CTRL_PARAM -- requirements
Module: traffic_ctrl_param

Interface
REQ-001 SHALL have parameter T_GREEN, default 22, green phase length in ticks (>=1).
REQ-002 SHALL have parameter T_YELLOW, default 3, yellow phase length in ticks (>=1).
REQ-003 SHALL have parameter T_ALLRED, default 1, all-red clearance length in ticks (>=1).
REQ-004 SHALL have parameter CNT_W, default 7, phase counter width; 2*T_ALLRED+T_GREEN+T_YELLOW-1 <= 99 and < 2^CNT_W.
REQ-005 SHALL have port clk, input, 1, single clock; one clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 SHALL have port tick, input, 1, single-cycle timing enable (nominally 1 Hz).
REQ-008 SHALL have port chedo, input, 1, mode: 1 = automatic, 0 = manual.
REQ-009 SHALL have port den, input, 1, manual request: 0 = line 1 green, 1 = line 2 green.
REQ-010 SHALL have port light1, output, 3, line 1 lamps {red,yellow,green}, one-hot.
REQ-011 SHALL have port light2, output, 3, line 2 lamps {red,yellow,green}, one-hot.
REQ-012 SHALL have ports bcd1, bcd2, output, 8 each, {tens,ones} BCD countdown per line.
REQ-013 SHALL have port disp_en, output, 1, countdown display valid.

Function
REQ-014 SHALL implement FSM G1 -> Y1 -> AR1 -> G2 -> Y2 -> AR2 -> G1; Gn = line n green, other red; Yn = line n yellow, other red; ARn = both red.
REQ-015 On phase entry cnt SHALL load phase length minus 1; on tick with cnt != 0, cnt decrements; on tick with cnt == 0, FSM advances; no state or cnt change when tick = 0.
REQ-016 light1/light2 SHALL decode combinationally from FSM state, zero latency.
REQ-017 Countdown line 1: G1/Y1/AR2 -> cnt; G2 -> cnt+T_YELLOW+T_ALLRED; Y2 -> cnt+T_ALLRED; AR1 -> cnt+T_GREEN+T_YELLOW+T_ALLRED.
REQ-018 Countdown line 2: mirror of REQ-017 with 1/2 swapped (G2/Y2/AR1 -> cnt; G1 -> cnt+T_YELLOW+T_ALLRED; etc.).
REQ-019 bcd1/bcd2 SHALL be binary-to-BCD of the countdown values, combinational from state/cnt; values never exceed 99.
REQ-020 disp_en SHALL be 1 only when chedo = 1 and no manual-exit reload is pending; bcd outputs are don't-care when disp_en = 0.
REQ-021 Manual (chedo = 0), in G1 with den = 0 or G2 with den = 1: FSM holds, cnt frozen.
REQ-022 Manual, in G1 with den = 1 (or G2 with den = 0): on next tick, enter Y1 (Y2) regardless of cnt; yellow and all-red then run full lengths.
REQ-023 Yellow and all-red phases SHALL always run to completion, in any mode; den changes during them do not abort.
REQ-024 At AR1/AR2 expiry in manual mode, next green SHALL be the line selected by den sampled on that tick (AR1 with den = 0 -> G1).
REQ-025 On chedo 0 -> 1 (registered edge detect), cnt SHALL reload to full length of current phase on that cycle; disp_en rises the following cycle.
REQ-026 On chedo 1 -> 0 during a green, cnt SHALL freeze; REQ-021/022 apply from that cycle.
REQ-027 Both lines green, or both yellow, SHALL be unreachable.

Reset
REQ-028 On clk edge with reset = 0: state = G1, cnt = T_GREEN-1, chedo edge register = 1, disp_en = 0; light1 = 001, light2 = 100.
REQ-029 Reset SHALL override tick and chedo on the same edge; mid-phase reset returns to G1 immediately.
REQ-030 disp_en SHALL be 1 on the first cycle after reset release if chedo = 1.

Verification
REQ-031 Reset, chedo = 1 -> light1 = 001, light2 = 100, bcd1 = 0x21, bcd2 = 0x25; after 22 ticks -> Y1, bcd1 = 0x02, bcd2 = 0x03.
REQ-032 Auto full cycle: sequence G1(22) Y1(3) AR1(1) G2(22) Y2(3) AR2(1) ticks; bcd2 = 0x00 in AR1, then 0x21 on G2 entry.
REQ-033 Manual den = 1 while in G1 (cnt = 10) -> Y1 on next tick, 3 ticks Y1, 1 tick AR1, G2 held indefinitely; disp_en = 0 throughout.
REQ-034 Manual, toggle den back to 0 during Y1 -> completes Y1, AR1, then G1 (not G2).
REQ-035 chedo 0 -> 1 while held in G2 -> cnt reloads 21, bcd2 = 0x21, bcd1 = 0x25, disp_en = 1 one cycle later.
REQ-036 reset asserted mid-Y2 with tick = 1 -> next cycle G1, cnt = 21, disp_en = 0; tick held 0 for 100 cycles -> no state change.
